// File: rtl/intadd_pkg.sv
// intadd_pkg: shared constants, state encoding and operand bundle for the intadd controller
package intadd_pkg;
    localparam logic [1:0] PREC_32  = 2'b11;
    localparam logic [1:0] PREC_4_8 = 2'b00;
    localparam logic MODE_32  = 1'b0;
    localparam logic MODE_4_8 = 1'b1;
    typedef enum logic [1:0] {IDLE, EXEC, WB0, WB1} state_t;
    typedef struct packed {
        logic         mode;
        logic [2:0]   sign;
        logic [127:0] src0;
        logic [127:0] src1;
        logic [127:0] src2;
    } op_t;
    // 4-bit element widened to an 8-bit addend; 32-bit sources contribute nothing here
    function automatic logic [7:0] nib_ext(input logic [3:0] n, input logic s, input logic [1:0] p);
        return p == PREC_32 ? 8'd0 : {{4{s & n[3]}}, n};
    endfunction
endpackage

// File: rtl/intadd.sv
// intadd: combinational lane adder, either four 32-bit lanes or thirty-two 4-bit
// elements (per-source signedness) summed into 8-bit results split over two registers
module intadd
    import intadd_pkg::*;
(
    input  logic         inst_valid,
    input  logic [127:0] src_reg0,
    input  logic [127:0] src_reg1,
    input  logic [127:0] src_reg2,
    input  logic [1:0]   precision_s0,
    input  logic [1:0]   precision_s1,
    input  logic [1:0]   precision_s2,
    input  logic         sign_s0,
    input  logic         sign_s1,
    input  logic         sign_s2,
    output logic [127:0] dst_reg0,
    output logic [127:0] dst_reg1
);
    logic [127:0] sum32;
    logic [255:0] sum8;
    logic         wide;
    assign wide = precision_s0 == PREC_32;
    always_comb begin
        sum32 = '0;
        sum8  = '0;
        for (int i = 0; i < 4; i++)
            sum32[32*i +: 32] = (precision_s0 == PREC_32 ? src_reg0[32*i +: 32] : 32'd0)
                              + (precision_s1 == PREC_32 ? src_reg1[32*i +: 32] : 32'd0)
                              + (precision_s2 == PREC_32 ? src_reg2[32*i +: 32] : 32'd0);
        for (int j = 0; j < 32; j++)
            sum8[8*j +: 8] = nib_ext(src_reg0[4*j +: 4], sign_s0, precision_s0)
                           + nib_ext(src_reg1[4*j +: 4], sign_s1, precision_s1)
                           + nib_ext(src_reg2[4*j +: 4], sign_s2, precision_s2);
    end
    assign dst_reg0 = !inst_valid ? '0 : wide ? sum32 : sum8[127:0];
    assign dst_reg1 = !inst_valid || wide ? '0 : sum8[255:128];
endmodule

// File: rtl/intadd_cmd_fifo.sv
// intadd_cmd_fifo: synchronous command FIFO; pushes when full and pops when empty are ignored
module intadd_cmd_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/intadd_ctrl.sv
// intadd_ctrl: buffers add commands, issues each to intadd for one cycle and
// returns one (32-bit) or two (4+8-bit) results over a valid/ready writeback port
module intadd_ctrl
    import intadd_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IDXW  = 5,
    parameter int CNTW  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_mode,
    input  logic [2:0]      cmd_sign,
    input  logic [127:0]    cmd_src0,
    input  logic [127:0]    cmd_src1,
    input  logic [127:0]    cmd_src2,
    input  logic [IDXW-1:0] cmd_dst0_idx,
    input  logic [IDXW-1:0] cmd_dst1_idx,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [IDXW-1:0] wb_idx,
    output logic [127:0]    wb_data,
    output logic            wb_last,
    output logic            busy,
    output logic [CNTW-1:0] done_cnt
);
    typedef struct packed {
        op_t            op;
        logic [IDXW-1:0] dst0_idx;
        logic [IDXW-1:0] dst1_idx;
    } cmd_t;
    state_t                 state;
    cmd_t                   in_cmd, head, cur;
    logic                   full, empty, pop, fin, inst_valid;
    logic [$clog2(DEPTH):0] count;
    logic [1:0]             prec;
    logic [127:0]           dst_reg0, dst_reg1, res1;
    assign in_cmd    = {cmd_mode, cmd_sign, cmd_src0, cmd_src1, cmd_src2, cmd_dst0_idx, cmd_dst1_idx};
    assign cmd_ready = !full;
    assign fin       = wb_ready && (state == WB1 || (state == WB0 && cur.op.mode == MODE_32));
    assign pop       = !empty && (state == IDLE || fin);
    assign busy      = state != IDLE || count != '0;
    assign prec      = cur.op.mode == MODE_4_8 ? PREC_4_8 : PREC_32;
    intadd_cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .pop   (pop),
        .din   (in_cmd),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    // Operands come straight from cur, so they stay put outside EXEC
    intadd u_intadd (
        .inst_valid   (inst_valid),
        .src_reg0     (cur.op.src0),
        .src_reg1     (cur.op.src1),
        .src_reg2     (cur.op.mode == MODE_4_8 ? cur.op.src2 : 128'd0),
        .precision_s0 (prec),
        .precision_s1 (prec),
        .precision_s2 (PREC_4_8),
        .sign_s0      (cur.op.sign[0]),
        .sign_s1      (cur.op.sign[1]),
        .sign_s2      (cur.op.mode & cur.op.sign[2]),
        .dst_reg0     (dst_reg0),
        .dst_reg1     (dst_reg1)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur        <= '0;
            res1       <= '0;
            inst_valid <= 1'b0;
            wb_valid   <= 1'b0;
            wb_idx     <= '0;
            wb_data    <= '0;
            wb_last    <= 1'b0;
            done_cnt   <= '0;
        end else begin
            inst_valid <= pop;
            if (pop) cur <= head;
            if (fin) begin
                wb_valid <= 1'b0;
                done_cnt <= done_cnt + CNTW'(1);
            end
            case (state)
                IDLE: if (pop) state <= EXEC;
                EXEC: begin
                    state    <= WB0;
                    wb_valid <= 1'b1;
                    wb_idx   <= cur.dst0_idx;
                    wb_data  <= dst_reg0;
                    wb_last  <= cur.op.mode == MODE_32;
                    res1     <= dst_reg1;
                end
                WB0: if (wb_ready) begin
                    if (cur.op.mode == MODE_4_8) begin
                        state   <= WB1;
                        wb_idx  <= cur.dst1_idx;
                        wb_data <= res1;
                        wb_last <= 1'b1;
                    end else state <= pop ? EXEC : IDLE;
                end
                WB1: if (wb_ready) state <= pop ? EXEC : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intadd_ctrl.sv
// tb_intadd_ctrl: directed bench for intadd_ctrl with hand-computed results
module tb_intadd_ctrl;
    logic         clk = 1'b0;
    logic         rst_n, cmd_valid, cmd_ready, cmd_mode, wb_valid, wb_ready, wb_last, busy;
    logic [2:0]   cmd_sign;
    logic [127:0] cmd_src0, cmd_src1, cmd_src2, wb_data;
    logic [4:0]   cmd_dst0_idx, cmd_dst1_idx, wb_idx;
    logic [31:0]  done_cnt;
    int errors = 0, checks = 0, cyc = 0;
    typedef struct {
        int           c;
        logic [4:0]   idx;
        logic [127:0] data;
        logic         last;
    } wb_t;
    wb_t log_q[$];
    // 4+8-bit vector: low half 7+15-7=0x0F per byte, high half -8+14-7=0xFF per byte
    localparam logic [127:0] S0 = 128'h8888888888888888_7777777777777777;
    localparam logic [127:0] S1 = 128'hEEEEEEEEEEEEEEEE_FFFFFFFFFFFFFFFF;
    localparam logic [127:0] S2 = {32{4'h9}};
    localparam logic [127:0] E0 = {16{8'h0F}};
    localparam logic [127:0] E1 = {16{8'hFF}};
    localparam logic [127:0] JUNK = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    logic [127:0] a5 [4], b5 [4], e5 [4];

    intadd_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_sign     (cmd_sign),
        .cmd_src0     (cmd_src0),
        .cmd_src1     (cmd_src1),
        .cmd_src2     (cmd_src2),
        .cmd_dst0_idx (cmd_dst0_idx),
        .cmd_dst1_idx (cmd_dst1_idx),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_idx       (wb_idx),
        .wb_data      (wb_data),
        .wb_last      (wb_last),
        .busy         (busy),
        .done_cnt     (done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (rst_n && wb_valid && wb_ready) log_q.push_back('{cyc, wb_idx, wb_data, wb_last});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic m, input logic [2:0] s, input logic [127:0] a, input logic [127:0] b,
                           input logic [127:0] c, input logic [4:0] d0, input logic [4:0] d1);
        cmd_mode = m;
        cmd_sign = s;
        cmd_src0 = a;
        cmd_src1 = b;
        cmd_src2 = c;
        cmd_dst0_idx = d0;
        cmd_dst1_idx = d1;
    endtask

    task automatic wait_wb(input string tag, input logic [4:0] idx, input logic [127:0] data, input logic last);
        int n = 0;
        while (wb_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, wb_valid, 1);
        chk({tag, "_idx"}, wb_idx, idx);
        chk({tag, "_data"}, wb_data, data);
        chk({tag, "_last"}, wb_last, last);
        step();
    endtask

    initial begin
        int n;
        a5[0] = {32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678, 32'h00000000};
        b5[0] = {32'h00000001, 32'h00000001, 32'h11111111, 32'h00000005};
        e5[0] = {32'h00000000, 32'h80000000, 32'h23456789, 32'h00000005};
        a5[1] = {4{32'd500}};  b5[1] = {4{32'd5}};  e5[1] = {4{32'd505}};
        a5[2] = {4{32'd600}};  b5[2] = {4{32'd6}};  e5[2] = {4{32'd606}};
        a5[3] = {4{32'd700}};  b5[3] = {4{32'd7}};  e5[3] = {4{32'd707}};
        // reset held with a command offered: nothing may be buffered
        rst_n = 1'b0;
        wb_ready = 1'b1;
        set_cmd(1'b0, 3'b000, {4{32'd9}}, {4{32'd9}}, '0, 5'd1, 5'd1);
        cmd_valid = 1'b1;
        repeat (3) step();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_idx", wb_idx, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_last", wb_last, 0);
        chk("rst_done", done_cnt, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", wb_valid, 0);
        // single 32-bit command, latency T+3
        set_cmd(1'b0, 3'b000, {4{32'h1}}, {4{32'h2}}, '0, 5'd3, 5'd0);
        cmd_valid = 1'b1;
        chk("t2_cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("t2_t1_valid", wb_valid, 0);
        chk("t2_t1_busy", busy, 1);
        step();
        chk("t2_exec_valid", wb_valid, 0);
        step();
        chk("t2_valid", wb_valid, 1);
        chk("t2_idx", wb_idx, 3);
        chk("t2_data", wb_data, {4{32'h3}});
        chk("t2_last", wb_last, 1);
        chk("t2_done_before", done_cnt, 0);
        step();
        chk("t2_valid_after", wb_valid, 0);
        chk("t2_done", done_cnt, 1);
        chk("t2_busy_after", busy, 0);
        // 4+8-bit command, two writebacks
        set_cmd(1'b1, 3'b101, S0, S1, S2, 5'd4, 5'd9);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("t3_wb0_valid", wb_valid, 1);
        chk("t3_wb0_idx", wb_idx, 4);
        chk("t3_wb0_data", wb_data, E0);
        chk("t3_wb0_last", wb_last, 0);
        step();
        chk("t3_wb1_valid", wb_valid, 1);
        chk("t3_wb1_idx", wb_idx, 9);
        chk("t3_wb1_data", wb_data, E1);
        chk("t3_wb1_last", wb_last, 1);
        step();
        chk("t3_valid_after", wb_valid, 0);
        chk("t3_done", done_cnt, 2);
        // backpressure in WB0 while the FIFO fills
        wb_ready = 1'b0;
        set_cmd(1'b0, 3'b111, {4{32'd100}}, {4{32'd1}}, JUNK, 5'd7, 5'd0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("t4_a_valid", wb_valid, 1);
        chk("t4_a_idx", wb_idx, 7);
        chk("t4_a_data", wb_data, {4{32'd101}});
        set_cmd(1'b0, 3'b111, {4{32'd200}}, {4{32'd2}}, JUNK, 5'd8, 5'd0);
        cmd_valid = 1'b1;
        chk("t4_ready_b", cmd_ready, 1);
        step();
        set_cmd(1'b0, 3'b111, {4{32'd300}}, {4{32'd3}}, JUNK, 5'd10, 5'd0);
        chk("t4_ready_c", cmd_ready, 1);
        chk("t4_hold_idx", wb_idx, 7);
        step();
        set_cmd(1'b0, 3'b111, {4{32'd400}}, {4{32'd4}}, JUNK, 5'd11, 5'd0);
        chk("t4_full", cmd_ready, 0);
        step();
        step();
        step();
        chk("t4_hold_valid", wb_valid, 1);
        chk("t4_hold_idx2", wb_idx, 7);
        chk("t4_hold_data", wb_data, {4{32'd101}});
        chk("t4_hold_last", wb_last, 1);
        chk("t4_hold_done", done_cnt, 2);
        wb_ready = 1'b1;
        step();
        chk("t4_done_a", done_cnt, 3);
        chk("t4_ready_d", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        wait_wb("t4_b", 5'd8, {4{32'd202}}, 1'b1);
        wait_wb("t4_c", 5'd10, {4{32'd303}}, 1'b1);
        wait_wb("t4_d", 5'd11, {4{32'd404}}, 1'b1);
        chk("t4_done", done_cnt, 6);
        chk("t4_busy", busy, 0);
        // back-to-back 32-bit commands
        log_q.delete();
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b0, 3'b010, a5[i], b5[i], JUNK, 5'(12 + i), 5'd0);
            cmd_valid = 1'b1;
            n = 0;
            while (!cmd_ready && n < 20) begin
                step();
                n++;
            end
            chk("t5_ready", cmd_ready, 1);
            step();
        end
        cmd_valid = 1'b0;
        n = 0;
        while (done_cnt != 32'd10 && n < 40) begin
            step();
            n++;
        end
        chk("t5_done", done_cnt, 10);
        step();
        chk("t5_busy", busy, 0);
        chk("t5_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("t5_idx", log_q[i].idx, 5'(12 + i));
            chk("t5_data", log_q[i].data, e5[i]);
            chk("t5_last", log_q[i].last, 1);
            if (i > 0) chk("t5_spacing", log_q[i].c - log_q[i-1].c, 2);
        end
        // reset while the second writeback is pending
        wb_ready = 1'b0;
        set_cmd(1'b1, 3'b101, S0, S1, S2, 5'd20, 5'd21);
        cmd_valid = 1'b1;
        step();
        set_cmd(1'b0, 3'b000, {4{32'd1}}, {4{32'd1}}, '0, 5'd22, 5'd0);
        step();
        cmd_valid = 1'b0;
        step();
        chk("t6_wb0_idx", wb_idx, 20);
        wb_ready = 1'b1;
        step();
        chk("t6_wb1_idx", wb_idx, 21);
        chk("t6_wb1_valid", wb_valid, 1);
        wb_ready = 1'b0;
        rst_n = 1'b0;
        step();
        log_q.delete();
        chk("t6_valid", wb_valid, 0);
        chk("t6_done", done_cnt, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", cmd_ready, 1);
        rst_n = 1'b1;
        wb_ready = 1'b1;
        repeat (8) step();
        chk("t6_no_wb", log_q.size(), 0);
        chk("t6_valid_after", wb_valid, 0);
        chk("t6_busy_after", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
